// File: rtl/rv32i_ctrl_pkg.sv
// rtl/rv32i_ctrl_pkg.sv - shared encodings for the multicycle RV32I control unit
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BRANCH,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Four-bit codes; a 3-bit ALU takes the low bits of the base ops.
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0001;
    localparam logic [3:0] ALUC_AND = 4'b0010;
    localparam logic [3:0] ALUC_OR  = 4'b0011;
    localparam logic [3:0] ALUC_SLT = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0100;
    localparam logic [3:0] ALUC_SLL = 4'b0110;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps ALUOp and funct fields to the ALU control code
module mc_alu_decoder
    import rv32i_ctrl_pkg::*;
#(
    parameter int ALUC_W = 3
) (
    input  logic [1:0]        aluop,
    input  logic              op5,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    output logic [ALUC_W-1:0] alucontrol
);

    localparam bit WIDE = (ALUC_W == 4);

    // Funct decode only when the FSM asks for it; unknown funct3 falls back to add.
    always_comb begin
        alucontrol = ALUC_ADD[ALUC_W-1:0];
        case (aluop)
            ALUOP_SUB: alucontrol = ALUC_SUB[ALUC_W-1:0];
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: alucontrol = (op5 & funct7_5) ? ALUC_SUB[ALUC_W-1:0]
                                                          : ALUC_ADD[ALUC_W-1:0];
                    3'b010: alucontrol = ALUC_SLT[ALUC_W-1:0];
                    3'b110: alucontrol = ALUC_OR[ALUC_W-1:0];
                    3'b111: alucontrol = ALUC_AND[ALUC_W-1:0];
                    3'b100: if (WIDE) alucontrol = ALUC_XOR[ALUC_W-1:0];
                    3'b001: if (WIDE) alucontrol = ALUC_SLL[ALUC_W-1:0];
                    3'b101: if (WIDE) alucontrol = funct7_5 ? ALUC_SRA[ALUC_W-1:0]
                                                            : ALUC_SRL[ALUC_W-1:0];
                    default: alucontrol = ALUC_ADD[ALUC_W-1:0];
                endcase
            end
            default: alucontrol = ALUC_ADD[ALUC_W-1:0];
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM sequencing a multicycle RV32I datapath
module multicycle_control_unit
    import rv32i_ctrl_pkg::*;
#(
    parameter int ALUC_W = 3,
    parameter int EN_BNE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        Op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              Zero,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic              instr_done,
    output logic              illegal_instr,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl
);

    state_t     state;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       taken;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // State register; reset wins over any transition, including memory stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECUTER;
                        OP_ITYPE:          state <= S_EXECUTEI;
                        OP_JAL:            state <= S_JAL;
                        OP_BRANCH:         state <= S_BRANCH;
                        default:           state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR:   state <= (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_JAL:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Per-state control word; only FETCH and MEMWRITE look at mem_ready.
    always_comb begin
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_WD;
        aluop         = ALUOP_ADD;
        pcupdate      = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                pcupdate  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_A;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                aluop      = ALUOP_SUB;
                instr_done = 1'b1;
            end
            S_ILLEGAL: illegal_instr = 1'b1;
            default: ;
        endcase
    end

    // Branch resolution from the ALU zero flag; bne support is optional.
    always_comb begin
        taken = 1'b0;
        if (funct3 == 3'b000)
            taken = Zero;
        else if (funct3 == 3'b001 && EN_BNE != 0)
            taken = ~Zero;
    end

    assign PCWrite = pcupdate | ((state == S_BRANCH) & taken);
    assign ImmSrc  = imm_src(Op);

    mc_alu_decoder #(
        .ALUC_W(ALUC_W)
    ) u_alu_decoder (
        .aluop      (aluop),
        .op5        (Op[5]),
        .funct3     (funct3),
        .funct7_5   (funct7[5]),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed-vector bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       mem_ready;

    logic       a_pcwrite, a_adrsrc, a_memwrite, a_irwrite, a_regwrite, a_done, a_illegal;
    logic [1:0] a_resultsrc, a_alusrca, a_alusrcb, a_immsrc;
    logic [2:0] a_aluc;
    logic       b_pcwrite, b_adrsrc, b_memwrite, b_irwrite, b_regwrite, b_done, b_illegal;
    logic [1:0] b_resultsrc, b_alusrca, b_alusrcb, b_immsrc;
    logic [3:0] b_aluc;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Default build: 3-bit ALU control, bne enabled.
    multicycle_control_unit #(.ALUC_W(3), .EN_BNE(1)) dut_a (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(a_pcwrite), .AdrSrc(a_adrsrc), .MemWrite(a_memwrite),
        .IRWrite(a_irwrite), .RegWrite(a_regwrite), .instr_done(a_done),
        .illegal_instr(a_illegal), .ResultSrc(a_resultsrc), .ALUSrcA(a_alusrca),
        .ALUSrcB(a_alusrcb), .ImmSrc(a_immsrc), .ALUControl(a_aluc)
    );

    // Alternate build: 4-bit ALU control, bne disabled.
    multicycle_control_unit #(.ALUC_W(4), .EN_BNE(0)) dut_b (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(b_pcwrite), .AdrSrc(b_adrsrc), .MemWrite(b_memwrite),
        .IRWrite(b_irwrite), .RegWrite(b_regwrite), .instr_done(b_done),
        .illegal_instr(b_illegal), .ResultSrc(b_resultsrc), .ALUSrcA(b_alusrca),
        .ALUSrcB(b_alusrcb), .ImmSrc(b_immsrc), .ALUControl(b_aluc)
    );

    wire [12:0] obs_a = {a_pcwrite, a_adrsrc, a_memwrite, a_irwrite, a_regwrite, a_done,
                         a_illegal, a_resultsrc, a_alusrca, a_alusrcb};
    wire [12:0] obs_b = {b_pcwrite, b_adrsrc, b_memwrite, b_irwrite, b_regwrite, b_done,
                         b_illegal, b_resultsrc, b_alusrca, b_alusrcb};

    // Control word: pcw adr mw irw rw done ill | ResultSrc ALUSrcA ALUSrcB
    function automatic logic [12:0] sig(input logic pcw, adr, mw, irw, rw, dn, il,
                                        input logic [1:0] rs, sa, sb);
        return {pcw, adr, mw, irw, rw, dn, il, rs, sa, sb};
    endfunction

    function automatic logic [12:0] e_fetch(input logic mr);
        return sig(mr, 0, 0, mr, 0, 0, 0, 2'b10, 2'b00, 2'b10);
    endfunction
    function automatic logic [12:0] e_memwrite(input logic mr);
        return sig(0, 1, 1, 0, 0, mr, 0, 2'b00, 2'b00, 2'b00);
    endfunction
    function automatic logic [12:0] e_branch(input logic t);
        return sig(t, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00);
    endfunction

    localparam logic [12:0] E_DECODE  = {7'b0000000, 2'b00, 2'b01, 2'b01};
    localparam logic [12:0] E_EXECR   = {7'b0000000, 2'b00, 2'b10, 2'b00};
    localparam logic [12:0] E_EXECI   = {7'b0000000, 2'b00, 2'b10, 2'b01};
    localparam logic [12:0] E_MEMADR  = {7'b0000000, 2'b00, 2'b10, 2'b01};
    localparam logic [12:0] E_ALUWB   = {7'b0000110, 2'b00, 2'b00, 2'b00};
    localparam logic [12:0] E_MEMREAD = {7'b0100000, 2'b00, 2'b00, 2'b00};
    localparam logic [12:0] E_MEMWB   = {7'b0000110, 2'b01, 2'b00, 2'b00};
    localparam logic [12:0] E_JAL     = {7'b1000000, 2'b00, 2'b01, 2'b10};
    localparam logic [12:0] E_ILLEGAL = {7'b0000001, 2'b00, 2'b00, 2'b00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check both control words mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [12:0] ea, input logic [12:0] eb);
        #1;
        check({tag, "/a"}, {19'd0, obs_a}, {19'd0, ea});
        check({tag, "/b"}, {19'd0, obs_b}, {19'd0, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic check_alu(input string tag, input logic [2:0] ea, input logic [3:0] eb);
        #1;
        check({tag, ".aluc/a"}, {29'd0, a_aluc}, {29'd0, ea});
        check({tag, ".aluc/b"}, {28'd0, b_aluc}, {28'd0, eb});
    endtask

    task automatic check_imm(input string tag, input logic [1:0] e);
        #1;
        check({tag, ".imm/a"}, {30'd0, a_immsrc}, {30'd0, e});
        check({tag, ".imm/b"}, {30'd0, b_immsrc}, {30'd0, e});
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] e3;
        logic [3:0] e4;
    } alu_vec_t;

    alu_vec_t alu_tab[10] = '{
        '{"add",  7'b0110011, 3'b000, 7'b0000000, 3'b000, 4'b0000},
        '{"sub",  7'b0110011, 3'b000, 7'b0100000, 3'b001, 4'b0001},
        '{"sra",  7'b0110011, 3'b101, 7'b0100000, 3'b000, 4'b1111},
        '{"srl",  7'b0110011, 3'b101, 7'b0000000, 3'b000, 4'b0111},
        '{"xor",  7'b0110011, 3'b100, 7'b0000000, 3'b000, 4'b0100},
        '{"sll",  7'b0110011, 3'b001, 7'b0000000, 3'b000, 4'b0110},
        '{"slt",  7'b0110011, 3'b010, 7'b0000000, 3'b101, 4'b0101},
        '{"or",   7'b0110011, 3'b110, 7'b0000000, 3'b011, 4'b0011},
        '{"and",  7'b0110011, 3'b111, 7'b0000000, 3'b010, 4'b0010},
        '{"addi", 7'b0010011, 3'b000, 7'b0100000, 3'b000, 4'b0000}
    };

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic ta, input logic tb);
        Op = 7'b1100011; funct3 = f3; funct7 = 7'd0; Zero = z; mem_ready = 1'b1;
        step({tag, ".fetch"}, e_fetch(1), e_fetch(1));
        check_imm(tag, 2'b10);
        step({tag, ".decode"}, E_DECODE, E_DECODE);
        check_alu(tag, 3'b001, 4'b0001);
        step({tag, ".branch"}, e_branch(ta), e_branch(tb));
    endtask

    initial begin
        rst = 1'b1; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU ops through EXECUTER / EXECUTEI and writeback
        foreach (alu_tab[i]) begin
            Op = alu_tab[i].op; funct3 = alu_tab[i].f3; funct7 = alu_tab[i].f7;
            step({alu_tab[i].name, ".fetch"}, e_fetch(1), e_fetch(1));
            step({alu_tab[i].name, ".decode"}, E_DECODE, E_DECODE);
            check_alu(alu_tab[i].name, alu_tab[i].e3, alu_tab[i].e4);
            if (alu_tab[i].op == 7'b0110011)
                step({alu_tab[i].name, ".exec"}, E_EXECR, E_EXECR);
            else
                step({alu_tab[i].name, ".exec"}, E_EXECI, E_EXECI);
            check_alu({alu_tab[i].name, ".wb"}, 3'b000, 4'b0000);
            step({alu_tab[i].name, ".aluwb"}, E_ALUWB, E_ALUWB);
        end

        // lw with fetch stall and a three-cycle read stall
        Op = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0; mem_ready = 1'b0;
        step("lw.fstall0", e_fetch(0), e_fetch(0));
        step("lw.fstall1", e_fetch(0), e_fetch(0));
        mem_ready = 1'b1;
        step("lw.fetch", e_fetch(1), e_fetch(1));
        check_imm("lw", 2'b00);
        step("lw.decode", E_DECODE, E_DECODE);
        mem_ready = 1'b0;
        step("lw.memadr", E_MEMADR, E_MEMADR);
        for (int k = 0; k < 3; k++)
            step("lw.rdstall", E_MEMREAD, E_MEMREAD);
        mem_ready = 1'b1;
        step("lw.memread", E_MEMREAD, E_MEMREAD);
        step("lw.memwb", E_MEMWB, E_MEMWB);

        // sw with one stall cycle then completion
        Op = 7'b0100011; funct3 = 3'b010;
        step("sw.fetch", e_fetch(1), e_fetch(1));
        check_imm("sw", 2'b01);
        step("sw.decode", E_DECODE, E_DECODE);
        step("sw.memadr", E_MEMADR, E_MEMADR);
        mem_ready = 1'b0;
        step("sw.wrstall", e_memwrite(0), e_memwrite(0));
        mem_ready = 1'b1;
        step("sw.memwrite", e_memwrite(1), e_memwrite(1));

        // sw interrupted by reset mid-stall
        step("swr.fetch", e_fetch(1), e_fetch(1));
        step("swr.decode", E_DECODE, E_DECODE);
        step("swr.memadr", E_MEMADR, E_MEMADR);
        mem_ready = 1'b0;
        step("swr.stall0", e_memwrite(0), e_memwrite(0));
        step("swr.stall1", e_memwrite(0), e_memwrite(0));
        rst = 1'b1;
        step("swr.rst", e_memwrite(0), e_memwrite(0));
        rst = 1'b0;
        step("swr.after", e_fetch(0), e_fetch(0));
        mem_ready = 1'b1;

        // Branches: b build has bne disabled
        run_branch("beq.z1", 3'b000, 1'b1, 1'b1, 1'b1);
        run_branch("beq.z0", 3'b000, 1'b0, 1'b0, 1'b0);
        run_branch("bne.z0", 3'b001, 1'b0, 1'b1, 1'b0);
        run_branch("bne.z1", 3'b001, 1'b1, 1'b0, 1'b0);
        run_branch("blt.z0", 3'b100, 1'b0, 1'b0, 1'b0);

        // jal
        Op = 7'b1101111; funct3 = 3'd0;
        step("jal.fetch", e_fetch(1), e_fetch(1));
        check_imm("jal", 2'b11);
        step("jal.decode", E_DECODE, E_DECODE);
        step("jal.jal", E_JAL, E_JAL);
        step("jal.aluwb", E_ALUWB, E_ALUWB);

        // Unknown opcode
        Op = 7'b1111111;
        step("ill.fetch", e_fetch(1), e_fetch(1));
        step("ill.decode", E_DECODE, E_DECODE);
        step("ill.illegal", E_ILLEGAL, E_ILLEGAL);
        mem_ready = 1'b0;
        step("ill.next", e_fetch(0), e_fetch(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
